// File: rtl/core_debug_ctrl.sv
// Host-command driven debug controller for Core: HALT / RUN / STEP n / READ reg, one response per command.
// Optional breakpoint stop while running is built when CORE_DEBUG_BP_EN is defined.
module core_debug_ctrl #(
  parameter int DATA_W   = 64,
  parameter int STEP_W   = 16,
  parameter int READ_LAT = 1,
  parameter int STEP_GAP = 1
) (
  input  logic              clk,
  input  logic              aresetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [STEP_W-1:0] cmd_arg,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              step,
  output logic              debug_mode,
  output logic [4:0]        debug_reg_addr,
  input  logic [DATA_W-1:0] debug_reg_data,
  input  logic [DATA_W-1:0] debug_pc,
  input  logic              bp_en,
  input  logic [DATA_W-1:0] bp_pc
);

  localparam logic [1:0] OP_HALT = 2'b00;
  localparam logic [1:0] OP_RUN  = 2'b01;
  localparam logic [1:0] OP_STEP = 2'b10;
  localparam logic [1:0] OP_READ = 2'b11;

  // One down-counter serves both the step gap and the read wait; it is loaded with N-1.
  localparam int WAIT_MAX = (READ_LAT > STEP_GAP) ? READ_LAT : STEP_GAP;
  localparam int WAIT_W   = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
  localparam logic [WAIT_W-1:0] GAP_LOAD  = WAIT_W'(STEP_GAP - 1);
  localparam logic [WAIT_W-1:0] READ_LOAD = WAIT_W'(READ_LAT - 1);

  typedef enum logic [2:0] {
    S_HALTED,
    S_RUNNING,
    S_STEP_HI,
    S_STEP_GAP,
    S_READ_WAIT,
    S_RESP
  } state_t;

  state_t             state;
  logic [STEP_W-1:0]  remain;
  logic [STEP_W-1:0]  step_total;
  logic [WAIT_W-1:0]  wait_cnt;
  logic               cmd_fire;
  logic               bp_hit;

  assign cmd_fire = cmd_valid && cmd_ready;

`ifdef CORE_DEBUG_BP_EN
  assign bp_hit = bp_en && (debug_pc == bp_pc);
`else
  logic unused_bp;
  assign unused_bp = ^{debug_pc, bp_en, bp_pc};
  assign bp_hit    = 1'b0;
`endif

  // NOTE: every register here uses <= so all state updates see pre-edge values, whatever the statement order.
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state          <= S_HALTED;
      cmd_ready      <= 1'b0;
      rsp_valid      <= 1'b0;
      rsp_data       <= '0;
      step           <= 1'b0;
      debug_mode     <= 1'b1;
      debug_reg_addr <= '0;
      remain         <= '0;
      step_total     <= '0;
      wait_cnt       <= '0;
    end else begin
      case (state)
        S_HALTED, S_RUNNING: begin
          cmd_ready <= 1'b1;
          if (cmd_fire) begin
            cmd_ready <= 1'b0;
            case (cmd_op)
              OP_HALT: begin
                debug_mode <= 1'b1;
                rsp_data   <= '0;
                rsp_valid  <= 1'b1;
                state      <= S_RESP;
              end
              OP_RUN: begin
                debug_mode <= 1'b0;
                rsp_data   <= '0;
                rsp_valid  <= 1'b1;
                state      <= S_RESP;
              end
              OP_STEP: begin
                debug_mode <= 1'b1;
                remain     <= cmd_arg;
                step_total <= cmd_arg;
                if (cmd_arg == '0) begin
                  rsp_data  <= '0;
                  rsp_valid <= 1'b1;
                  state     <= S_RESP;
                end else if (state == S_RUNNING) begin
                  // Spend one gated cycle so the first pulse never overlaps free-run.
                  wait_cnt <= '0;
                  state    <= S_STEP_GAP;
                end else begin
                  step  <= 1'b1;
                  state <= S_STEP_HI;
                end
              end
              default: begin
                debug_reg_addr <= cmd_arg[4:0];
                wait_cnt       <= READ_LOAD;
                state          <= S_READ_WAIT;
              end
            endcase
          end else if ((state == S_RUNNING) && bp_hit) begin
            debug_mode <= 1'b1;
            state      <= S_HALTED;
          end
        end

        S_STEP_HI: begin
          step     <= 1'b0;
          remain   <= remain - 1'b1;
          wait_cnt <= GAP_LOAD;
          state    <= S_STEP_GAP;
        end

        S_STEP_GAP: begin
          if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - 1'b1;
          end else if (remain == '0) begin
            rsp_data  <= DATA_W'(step_total);
            rsp_valid <= 1'b1;
            state     <= S_RESP;
          end else begin
            step  <= 1'b1;
            state <= S_STEP_HI;
          end
        end

        S_READ_WAIT: begin
          if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - 1'b1;
          end else begin
            rsp_data  <= debug_reg_data;
            rsp_valid <= 1'b1;
            state     <= S_RESP;
          end
        end

        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= debug_mode ? S_HALTED : S_RUNNING;
          end
        end

        default: begin
          state     <= S_HALTED;
          cmd_ready <= 1'b0;
          rsp_valid <= 1'b0;
          step      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_core_debug_ctrl.sv
// Directed self-checking bench for core_debug_ctrl (READ_LAT=2, STEP_GAP=1); breakpoint steps
// are included when CORE_DEBUG_BP_EN is defined.
module tb_core_debug_ctrl;

  localparam int DATA_W = 64;
  localparam int STEP_W = 16;
  localparam logic [1:0] OP_HALT = 2'b00;
  localparam logic [1:0] OP_RUN  = 2'b01;
  localparam logic [1:0] OP_STEP = 2'b10;
  localparam logic [1:0] OP_READ = 2'b11;

  logic              clk = 1'b0;
  logic              aresetn;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [STEP_W-1:0] cmd_arg;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              step;
  logic              debug_mode;
  logic [4:0]        debug_reg_addr;
  logic [DATA_W-1:0] debug_reg_data;
  logic [DATA_W-1:0] debug_pc = 64'h8000_0000;
  logic              bp_en;
  logic [DATA_W-1:0] bp_pc;

  int n_checks = 0;
  int n_fail   = 0;

  core_debug_ctrl #(
    .DATA_W(DATA_W), .STEP_W(STEP_W), .READ_LAT(2), .STEP_GAP(1)
  ) dut (
    .clk(clk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .step(step), .debug_mode(debug_mode),
    .debug_reg_addr(debug_reg_addr), .debug_reg_data(debug_reg_data),
    .debug_pc(debug_pc), .bp_en(bp_en), .bp_pc(bp_pc)
  );

  always #5 clk = ~clk;

  // Core register file model: upper word is a marker, low bits echo the index.
  assign debug_reg_data = {32'hDEAD_BEEF, 27'd0, debug_reg_addr};

  // Core PC model: advances by 4 per free-running clock once breakpoint testing starts.
  always @(posedge clk) if (bp_en && !debug_mode) debug_pc <= debug_pc + 64'd4;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Present one command for a single edge; the controller must be ready beforehand.
  task automatic send(input logic [1:0] op, input logic [STEP_W-1:0] arg);
    check("cmd_ready_before_send", cmd_ready, 1'b1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    cyc();
    cmd_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, cmd_ready, 1'b0);
    check({tag, "_rsp_valid"}, rsp_valid, 1'b0);
    check({tag, "_rsp_data"}, rsp_data, 64'd0);
    check({tag, "_step"}, step, 1'b0);
    check({tag, "_debug_mode"}, debug_mode, 1'b1);
    check({tag, "_addr"}, debug_reg_addr, 5'd0);
  endtask

  logic [5:0] pat3;
  logic [4:0] pat_run2;
  bit         found;

  initial begin
    aresetn   = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = OP_HALT;
    cmd_arg   = '0;
    rsp_ready = 1'b1;
    bp_en     = 1'b0;
    bp_pc     = 64'h8000_0010;
    pat3      = 6'b101010;
    pat_run2  = 5'b01010;

    // Reset held for two edges, then released.
    cyc(); cyc();
    check_reset_outputs("reset_hold");
    aresetn = 1'b1;
    cyc();
    check("release_cmd_ready", cmd_ready, 1'b1);
    check("release_debug_mode", debug_mode, 1'b1);
    check("release_step", step, 1'b0);
    check("release_rsp_valid", rsp_valid, 1'b0);

    // STEP 3 from HALTED: 1,0,1,0,1,0 then response 3.
    send(OP_STEP, 16'd3);
    for (int i = 0; i < 6; i++) begin
      check("step3_pulse", step, pat3[5-i]);
      check("step3_ready_low", cmd_ready, 1'b0);
      check("step3_no_rsp", rsp_valid, 1'b0);
      cyc();
    end
    check("step3_rsp_valid", rsp_valid, 1'b1);
    check("step3_rsp_data", rsp_data, 64'd3);
    check("step3_step_idle", step, 1'b0);
    cyc();
    check("step3_done_rsp_valid", rsp_valid, 1'b0);
    check("step3_done_ready", cmd_ready, 1'b1);
    check("step3_done_mode", debug_mode, 1'b1);

    // READ 10 with junk in the upper argument bits, two wait cycles.
    send(OP_READ, 16'hFFEA);
    check("read_addr", debug_reg_addr, 5'd10);
    check("read_wait1_rsp", rsp_valid, 1'b0);
    cyc();
    check("read_wait2_rsp", rsp_valid, 1'b0);
    cyc();
    check("read_rsp_valid", rsp_valid, 1'b1);
    check("read_rsp_data", rsp_data, 64'hDEAD_BEEF_0000_000A);
    cyc();
    check("read_done_rsp", rsp_valid, 1'b0);
    check("read_addr_held", debug_reg_addr, 5'd10);
    check("read_mode_same", debug_mode, 1'b1);

    // RUN then HALT, each response back-pressured for 4 cycles.
    rsp_ready = 1'b0;
    send(OP_RUN, 16'd0);
    for (int i = 0; i < 4; i++) begin
      check("run_rsp_held", rsp_valid, 1'b1);
      check("run_rsp_data", rsp_data, 64'd0);
      check("run_ready_low", cmd_ready, 1'b0);
      check("run_mode", debug_mode, 1'b0);
      if (i < 3) cyc();
    end
    rsp_ready = 1'b1;
    cyc();
    check("run_done_rsp", rsp_valid, 1'b0);
    check("run_done_ready", cmd_ready, 1'b1);
    check("run_done_mode", debug_mode, 1'b0);
    rsp_ready = 1'b0;
    send(OP_HALT, 16'd0);
    for (int i = 0; i < 4; i++) begin
      check("halt_rsp_held", rsp_valid, 1'b1);
      check("halt_rsp_data", rsp_data, 64'd0);
      check("halt_ready_low", cmd_ready, 1'b0);
      check("halt_mode", debug_mode, 1'b1);
      if (i < 3) cyc();
    end
    rsp_ready = 1'b1;
    cyc();
    check("halt_done_rsp", rsp_valid, 1'b0);
    check("halt_done_ready", cmd_ready, 1'b1);

    // STEP 0: no pulse, response the next cycle.
    send(OP_STEP, 16'd0);
    check("step0_rsp_valid", rsp_valid, 1'b1);
    check("step0_rsp_data", rsp_data, 64'd0);
    check("step0_step", step, 1'b0);
    cyc();

    // STEP 2 from RUNNING: a gated idle cycle first, then 1,0,1,0, response 2.
    send(OP_RUN, 16'd0);
    cyc();
    check("run2_mode", debug_mode, 1'b0);
    send(OP_STEP, 16'd2);
    for (int i = 0; i < 5; i++) begin
      check("run2_mode_forced", debug_mode, 1'b1);
      check("run2_pulse", step, pat_run2[4-i]);
      cyc();
    end
    check("run2_rsp_valid", rsp_valid, 1'b1);
    check("run2_rsp_data", rsp_data, 64'd2);
    cyc();
    check("run2_done_ready", cmd_ready, 1'b1);

    // Reset asserted during the 2nd pulse of STEP 5: everything back to reset, no response.
    send(OP_STEP, 16'd5);
    check("rst5_pulse1", step, 1'b1);
    cyc();
    check("rst5_gap1", step, 1'b0);
    cyc();
    check("rst5_pulse2", step, 1'b1);
    aresetn = 1'b0;
    cyc();
    check_reset_outputs("rst5_reset");
    aresetn = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cyc();
      check("rst5_no_rsp", rsp_valid, 1'b0);
      check("rst5_no_step", step, 1'b0);
    end
    check("rst5_ready", cmd_ready, 1'b1);

`ifdef CORE_DEBUG_BP_EN
    // Breakpoint at 0x80000010 while the PC climbs by 4 from 0x80000000.
    bp_en = 1'b1;
    send(OP_RUN, 16'd0);
    check("bp_run_rsp", rsp_valid, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cyc();
      if (debug_pc == 64'h8000_0010) found = 1'b1;
    end
    check("bp_pc_reached", found, 1'b1);
    check("bp_mode_at_hit", debug_mode, 1'b0);
    cyc();
    check("bp_mode_after", debug_mode, 1'b1);
    check("bp_no_rsp", rsp_valid, 1'b0);
    check("bp_ready", cmd_ready, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("bp_still_no_rsp", rsp_valid, 1'b0);
      check("bp_still_halted", debug_mode, 1'b1);
    end
    bp_en = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
